smpl_core_gen: RTL and testbench

Parametrised multicycle accumulator processor, the next generation of `smpl_core`. It runs the existing ADD/SUB/AND/LDA instruction set over configurable data and address widths, and adds STA, XOR, JMP and JZ. It also adds a `dready` wait-state handshake on the data port and exposes zero/carry flags. The block sits between an asynchronous-read instruction ROM and a data memory that may stall.

---
 rtl/smpl_pkg.sv | 27 ++
 rtl/smpl_alu.sv | 42 ++++
 rtl/smpl_core_gen.sv | 151 +++++++++++++++
 tb/tb_smpl_core_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/smpl_pkg.sv
// Shared types for the smpl_core_gen accumulator processor: opcodes,
// FSM states and instruction-width helper.
package smpl_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_LDA = 3'b100,
        OP_STA = 3'b101,
        OP_JMP = 3'b110,
        OP_JZ  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2
    } state_e;

    // Instruction word = 3-bit opcode on top of an AW-bit operand address.
    function automatic int instr_width(input int aw);
        return aw + 3;
    endfunction

endpackage

// File: rtl/smpl_alu.sv
// Combinational ALU: one DW+1-bit adder shared by ADD and SUB, plus the
// bitwise ops and a load pass-through. Zero is taken from the result.
module smpl_alu
    import smpl_pkg::*;
#(
    parameter int DW = 16
) (
    input  opcode_e       op,
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] operand,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          zero
);

    logic          is_sub;
    logic [DW:0]   b_ext;
    logic [DW:0]   sum;

    // SUB is acc + ~operand + 1, so the adder carry-out is the not-borrow.
    always_comb begin
        is_sub = (op == OP_SUB);
        b_ext  = is_sub ? {1'b0, ~operand} : {1'b0, operand};
        sum    = {1'b0, acc} + b_ext + {{DW{1'b0}}, is_sub};
    end

    // Result select; opcodes with no data result pass the accumulator through.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        result = acc;
        carry  = sum[DW];
        case (op)
            OP_ADD, OP_SUB: result = sum[DW-1:0];
            OP_AND:         result = acc & operand;
            OP_XOR:         result = acc ^ operand;
            OP_LDA:         result = operand;
            default:        result = acc;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/smpl_core_gen.sv
// Multicycle accumulator processor: FETCH -> EXEC -> (MEM) with a dready
// wait-state handshake on the data port. All outputs come from flops.
module smpl_core_gen
    import smpl_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 13
) (
    input  logic          clock,
    input  logic          reset,
    output logic [AW-1:0] iaddr,
    input  logic [AW+2:0] idata,
    output logic [AW-1:0] daddr,
    input  logic [DW-1:0] datai,
    output logic [DW-1:0] datao,
    output logic          renbl,
    output logic          wenbl,
    input  logic          dready,
    output logic          zflag,
    output logic          cflag
);

    localparam int IW = instr_width(AW);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [AW-1:0] daddr_q, daddr_d;
    logic [DW-1:0] datao_q, datao_d;
    logic          renbl_q, renbl_d;
    logic          wenbl_q, wenbl_d;
    logic          zflag_q, zflag_d;
    logic          cflag_q, cflag_d;

    opcode_e       op;
    logic [AW-1:0] opnd_addr;
    logic [DW-1:0] alu_result;
    logic          alu_carry;
    logic          alu_zero;

    // Decode fields of the latched instruction.
    always_comb begin
        op        = opcode_e'(ir_q[IW-1:AW]);
        opnd_addr = ir_q[AW-1:0];
    end

    smpl_alu #(.DW(DW)) u_alu (
        .op      (op),
        .acc     (acc_q),
        .operand (datai),
        .result  (alu_result),
        .carry   (alu_carry),
        .zero    (alu_zero)
    );

    // Next-state logic: instruction sequencing and data-port handshake.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        daddr_d = daddr_q;
        datao_d = datao_q;
        renbl_d = renbl_q;
        wenbl_d = wenbl_q;
        zflag_d = zflag_q;
        cflag_d = cflag_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = idata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op == OP_JMP) begin
                    pc_d    = opnd_addr;
                    state_d = S_FETCH;
                end else if (op == OP_JZ) begin
                    pc_d    = zflag_q ? opnd_addr : pc_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    daddr_d = opnd_addr;
                    if (op == OP_STA) begin
                        wenbl_d = 1'b1;
                        datao_d = acc_q;
                    end else begin
                        renbl_d = 1'b1;
                    end
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                // Requests stay asserted and stable until the memory completes.
                if (dready) begin
                    if (renbl_q) begin
                        acc_d   = alu_result;
                        zflag_d = alu_zero;
                        if (op == OP_ADD || op == OP_SUB) begin
                            cflag_d = alu_carry;
                        end
                    end
                    pc_d    = pc_q + 1'b1;
                    renbl_d = 1'b0;
                    wenbl_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State registers with synchronous active-low reset; reset wins in every state.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            daddr_q <= '0;
            datao_q <= '0;
            renbl_q <= 1'b0;
            wenbl_q <= 1'b0;
            zflag_q <= 1'b0;
            cflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            daddr_q <= daddr_d;
            datao_q <= datao_d;
            renbl_q <= renbl_d;
            wenbl_q <= wenbl_d;
            zflag_q <= zflag_d;
            cflag_q <= cflag_d;
        end
    end

    // Outputs are driven straight from flops.
    always_comb begin
        iaddr = pc_q;
        daddr = daddr_q;
        datao = datao_q;
        renbl = renbl_q;
        wenbl = wenbl_q;
        zflag = zflag_q;
        cflag = cflag_q;
    end

endmodule

// File: tb/tb_smpl_core_gen.sv
// Directed bench for smpl_core_gen: a reference model pushes expected
// architectural state per instruction; it is popped and compared when the
// DUT returns to FETCH.
module tb_smpl_core_gen;
    import smpl_pkg::*;

    localparam int DW = 16;
    localparam int AW = 13;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] iaddr;
    logic [AW+2:0] idata = '0;
    logic [AW-1:0] daddr;
    logic [DW-1:0] datai = '0;
    logic [DW-1:0] datao;
    logic          renbl;
    logic          wenbl;
    logic          dready = 1'b1;
    logic          zflag;
    logic          cflag;

    smpl_core_gen #(.DW(DW), .AW(AW)) dut (
        .clock  (clock),
        .reset  (reset),
        .iaddr  (iaddr),
        .idata  (idata),
        .daddr  (daddr),
        .datai  (datai),
        .datao  (datao),
        .renbl  (renbl),
        .wenbl  (wenbl),
        .dready (dready),
        .zflag  (zflag),
        .cflag  (cflag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] acc;
        logic [AW-1:0] pc;
        logic          z;
        logic          c;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    logic [DW-1:0] m_acc = '0;
    logic [AW-1:0] m_pc  = '0;
    logic          m_z   = 1'b0;
    logic          m_c   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one instruction and queue the expected state.
    task automatic model_push(input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] din);
        exp_t e;
        logic [DW:0] wide;
        case (op)
            3'b000: begin wide = {1'b0, m_acc} + {1'b0, din}; m_acc = wide[DW-1:0]; m_c = wide[DW]; end
            3'b001: begin m_c = (m_acc >= din); m_acc = m_acc - din; end
            3'b010: m_acc = m_acc & din;
            3'b011: m_acc = m_acc ^ din;
            3'b100: m_acc = din;
            default: ;
        endcase
        if (op <= 3'b100) m_z = (m_acc == 0);
        if (op == 3'b110)      m_pc = a;
        else if (op == 3'b111) m_pc = m_z ? a : m_pc + 13'd1;
        else                   m_pc = m_pc + 13'd1;
        e.acc = m_acc; e.pc = m_pc; e.z = m_z; e.c = m_c;
        sb.push_back(e);
    endtask

    // Run one instruction from FETCH, checking handshakes each cycle.
    task automatic run_instr(input string tag, input logic [2:0] op, input logic [AW-1:0] a,
                             input logic [DW-1:0] din, input int waits);
        exp_t          e;
        logic [AW-1:0] pc0;
        logic [DW-1:0] acc0;
        pc0  = m_pc;
        acc0 = m_acc;
        model_push(op, a, din);
        idata  = {op, a};
        datai  = din;
        dready = 1'b1;                    // must be ignored outside MEM
        @(posedge clock); #1;             // now in EXEC
        check({tag, ".exec_req"}, {renbl, wenbl}, 2'b00);
        check({tag, ".exec_pc"}, iaddr, pc0);
        if (op < 3'b110) begin
            @(posedge clock); #1;         // now in MEM
            if (waits > 0) dready = 1'b0;
            for (int i = 0; i <= waits; i++) begin
                if (i == waits) dready = 1'b1;
                check({tag, ".mem_ren"}, renbl, (op != 3'b101));
                check({tag, ".mem_wen"}, wenbl, (op == 3'b101));
                check({tag, ".mem_daddr"}, daddr, a);
                if (op == 3'b101) check({tag, ".mem_datao"}, datao, acc0);
                check({tag, ".mem_pc"}, iaddr, pc0);
                @(posedge clock); #1;
            end
            check({tag, ".done_req"}, {renbl, wenbl}, 2'b00);
        end else begin
            @(posedge clock); #1;
        end
        check({tag, ".state"}, dut.state_q, S_FETCH);
        e = sb.pop_front();
        check({tag, ".pc"}, iaddr, e.pc);
        check({tag, ".acc"}, dut.acc_q, e.acc);
        check({tag, ".zflag"}, zflag, e.z);
        check({tag, ".cflag"}, cflag, e.c);
    endtask

    initial begin
        // Reset for two cycles with dready high
        reset = 1'b0; dready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst.iaddr", iaddr, 0);
        check("rst.daddr", daddr, 0);
        check("rst.datao", datao, 0);
        check("rst.req", {renbl, wenbl}, 2'b00);
        check("rst.flags", {zflag, cflag}, 2'b00);
        check("rst.acc", dut.acc_q, 0);
        check("rst.state", dut.state_q, S_FETCH);
        reset = 1'b1;

        // Arithmetic and flags
        run_instr("add1", 3'b000, 13'h0001, 16'h0001, 0);
        run_instr("sub0", 3'b001, 13'h0002, 16'h0001, 0);
        run_instr("subm", 3'b001, 13'h0002, 16'h0001, 0);
        run_instr("addw", 3'b000, 13'h0003, 16'h0001, 0);   // FFFF+1 wraps, carry set
        // Logic ops; LDA must leave cflag untouched
        run_instr("lda",  3'b100, 13'h0004, 16'h1757, 0);
        run_instr("and",  3'b010, 13'h0005, 16'h0015, 1);
        run_instr("xor",  3'b011, 13'h0006, 16'h00FF, 0);
        // Store with three wait states
        run_instr("sta",  3'b101, 13'h0100, 16'h5A5A, 3);
        // Jumps and PC wrap
        run_instr("jmp",  3'b110, 13'h1FFF, 16'h0000, 0);
        run_instr("jznt", 3'b111, 13'h0003, 16'h0000, 0);   // z=0: 1FFF+1 wraps to 0
        run_instr("lda0", 3'b100, 13'h0007, 16'h0000, 0);
        run_instr("jzt",  3'b111, 13'h0005, 16'h0000, 0);
        run_instr("lda42",3'b100, 13'h0008, 16'h0042, 0);

        // Reset in the middle of a stalled read
        idata = {3'b000, 13'h0009}; datai = 16'h0005; dready = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        dready = 1'b0;
        check("abort.mem_ren", renbl, 1'b1);
        @(posedge clock); #1;
        check("abort.wait_ren", renbl, 1'b1);
        reset = 1'b0; dready = 1'b1;
        @(posedge clock); #1;
        check("abort.ren", renbl, 1'b0);
        check("abort.pc", iaddr, 0);
        check("abort.acc", dut.acc_q, 0);
        check("abort.flags", {zflag, cflag}, 2'b00);
        check("abort.state", dut.state_q, S_FETCH);
        m_acc = '0; m_pc = '0; m_z = 1'b0; m_c = 1'b0;
        reset = 1'b1;
        run_instr("recov", 3'b100, 13'h000A, 16'h0007, 0);

        check("sb.empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
